// File: rtl/fnd_scan_if.sv
// fnd_scan_if: bundle between the display requesters/consumer and the FND scan scheduler.
//   master : drives a_req/a_data, b_req/b_data, prio_b, digit_en; receives the rest
//   slave  : the scheduler; drives a_ack, b_ack, fndsel, digit_data, frame_start, owner
interface fnd_scan_if;
  logic        a_req;
  logic [15:0] a_data;
  logic        a_ack;
  logic        b_req;
  logic [15:0] b_data;
  logic        b_ack;
  logic        prio_b;
  logic [3:0]  digit_en;
  logic [3:0]  fndsel;
  logic [3:0]  digit_data;
  logic        frame_start;
  logic        owner;

  modport master (
    output a_req, a_data, b_req, b_data, prio_b, digit_en,
    input  a_ack, b_ack, fndsel, digit_data, frame_start, owner
  );

  modport slave (
    input  a_req, a_data, b_req, b_data, prio_b, digit_en,
    output a_ack, b_ack, fndsel, digit_data, frame_start, owner
  );
endinterface

// File: rtl/fnd_scan_sched.sv
// fnd_scan_sched: 4-digit FND scan scheduler with two-source frame-boundary arbiter.
//   clk, reset (sync, active-high)
//   bus (fnd_scan_if.slave): a_req/a_data/a_ack, b_req/b_data/b_ack, prio_b, digit_en,
//        fndsel (active-low anodes), digit_data (nibble to decoder), frame_start, owner
// Each digit owns a slot of CLK_HZ/SCAN_HZ cycles; the first BLANK_CYC cycles of a
// slot keep every anode off to avoid ghosting. Displayed data lives in a shadow
// register that only changes at the frame boundary (last cycle of digit 3's slot).
// Optional: FND_LEADZERO_BLANK_EN suppresses leading zero digits 3..1.
module fnd_scan_sched #(
  parameter int CLK_HZ    = 100000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  fnd_scan_if.slave  bus
);
  localparam int SLOT  = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (SLOT > 2) ? $clog2(SLOT) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [3:0][3:0]  shadow, shadow_nxt;
  logic             owner_nxt;
  logic             wrap, frame_end, grant_a, grant_b;
  logic [3:0]       lit;

  // Outputs are registered from next-state values so that what appears in a
  // cycle matches the cnt/idx/shadow of that same cycle.
  always_comb begin
    wrap       = (cnt == SLOT_LAST);
    frame_end  = wrap && (idx == 2'd3);
    cnt_nxt    = wrap ? '0 : cnt + 1'b1;
    idx_nxt    = wrap ? idx + 2'd1 : idx;
    grant_a    = frame_end && bus.a_req && (!bus.b_req || !bus.prio_b);
    grant_b    = frame_end && bus.b_req && !grant_a;
    shadow_nxt = shadow;
    owner_nxt  = bus.owner;
    if (grant_a) begin
      shadow_nxt = bus.a_data;
      owner_nxt  = 1'b0;
    end else if (grant_b) begin
      shadow_nxt = bus.b_data;
      owner_nxt  = 1'b1;
    end
    state_nxt = state;
    case (state)
      ST_BLANK: if (cnt_nxt == BLANK_END) state_nxt = ST_SHOW;
      ST_SHOW:  if (wrap)                 state_nxt = ST_BLANK;
      default:                            state_nxt = ST_BLANK;
    endcase
  end

  // Per-digit light enable; leading-zero test looks at the data being shown next.
  for (genvar i = 0; i < 4; i++) begin : g_lit
`ifdef FND_LEADZERO_BLANK_EN
    if (i == 0) begin : g_d0
      assign lit[i] = bus.digit_en[i];
    end else begin : g_dn
      assign lit[i] = bus.digit_en[i] && (|shadow_nxt[3:i]);
    end
`else
    assign lit[i] = bus.digit_en[i];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_BLANK;
      cnt             <= '0;
      idx             <= '0;
      shadow          <= '0;
      bus.owner       <= 1'b0;
      bus.fndsel      <= 4'hF;
      bus.digit_data  <= 4'h0;
      bus.a_ack       <= 1'b0;
      bus.b_ack       <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      idx             <= idx_nxt;
      shadow          <= shadow_nxt;
      bus.owner       <= owner_nxt;
      bus.fndsel      <= (state_nxt == ST_SHOW && lit[idx_nxt]) ? ~(4'b0001 << idx_nxt) : 4'hF;
      bus.digit_data  <= shadow_nxt[idx_nxt];
      bus.a_ack       <= grant_a;
      bus.b_ack       <= grant_b;
      bus.frame_start <= frame_end;
    end
  end
endmodule

// File: tb/tb_fnd_scan_sched.sv
// tb_fnd_scan_sched: directed + randomized bench for fnd_scan_sched with
// SLOT=10, BLANK_CYC=2. A frame-level reference model (cycle index modulo 40,
// shadow/owner updated by the arbitration rule) predicts every output each cycle.
module tb_fnd_scan_sched;
  logic clk = 1'b0;
  logic reset;
  fnd_scan_if bus();

  fnd_scan_sched #(.CLK_HZ(100), .SCAN_HZ(10), .BLANK_CYC(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          t = 0;          // cycles since reset release (0 = reset cycle)
  logic [15:0] m_shadow = '0;
  logic        m_owner = 1'b0;
  logic        ea = 1'b0, eb = 1'b0;
  int          n_a_ack = 0, n_b_ack = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs the DUT just sampled, then
  // compare every output. Inputs are changed by callers only after this returns.
  task automatic cyc();
    int pos, idx, c;
    logic       lit;
    logic [3:0] efs;
    @(posedge clk);
    #1;
    ea = 1'b0;
    eb = 1'b0;
    if (reset) begin
      t = 0;
      m_shadow = '0;
      m_owner = 1'b0;
    end else begin
      t++;
      if (t % 40 == 0) begin
        if (bus.a_req && (!bus.b_req || !bus.prio_b)) begin
          ea = 1'b1; m_shadow = bus.a_data; m_owner = 1'b0;
        end else if (bus.b_req) begin
          eb = 1'b1; m_shadow = bus.b_data; m_owner = 1'b1;
        end
      end
    end
    pos = t % 40;
    idx = pos / 10;
    c   = pos % 10;
    lit = bus.digit_en[idx];
`ifdef FND_LEADZERO_BLANK_EN
    if (idx > 0 && (m_shadow >> (4 * idx)) == 16'h0) lit = 1'b0;
`endif
    efs = 4'hF;
    if (c >= 2 && lit) efs[idx] = 1'b0;
    chk("fndsel",      {12'h0, bus.fndsel},      {12'h0, efs});
    chk("digit_data",  {12'h0, bus.digit_data},  {12'h0, 4'((m_shadow >> (4 * idx)) & 16'hF)});
    chk("frame_start", {15'h0, bus.frame_start}, {15'h0, (t > 0 && pos == 0)});
    chk("a_ack",       {15'h0, bus.a_ack},       {15'h0, ea});
    chk("b_ack",       {15'h0, bus.b_ack},       {15'h0, eb});
    chk("owner",       {15'h0, bus.owner},       {15'h0, m_owner});
    // requesters release on their own grant
    if (ea) begin bus.a_req = 1'b0; n_a_ack++; end
    if (eb) begin bus.b_req = 1'b0; n_b_ack++; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < 80 && (t % 40) != p; i++) cyc();
  endtask

  initial begin
    reset        = 1'b1;
    bus.a_req    = 1'b0;
    bus.a_data   = '0;
    bus.b_req    = 1'b0;
    bus.b_data   = '0;
    bus.prio_b   = 1'b0;
    bus.digit_en = 4'hF;
    run(3);
    reset = 1'b0;

    // idle scan, two frames
    run(80);

    // single request from A
    bus.a_data = 16'h1234;
    bus.a_req  = 1'b1;
    run(90);
    chk("a_granted", 16'(n_a_ack), 16'd1);

    // contention, B has priority
    bus.prio_b = 1'b1;
    bus.a_data = 16'h5A5A;
    bus.b_data = 16'hBEEF;
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    run(100);
    chk("both_granted", 16'(n_a_ack + n_b_ack), 16'd3);

    // masked digits 1 and 3
    bus.digit_en = 4'b0101;
    run(90);
    bus.digit_en = 4'hF;

    // reset mid-slot (cnt=5, idx=2) with B pending
    bus.b_data = 16'hC0DE;
    run_to_pos(10);
    bus.b_req = 1'b1;
    run_to_pos(25);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    run(90);

    // small values exercise leading-zero handling
    bus.prio_b = 1'b0;
    bus.a_data = 16'h0007;
    bus.a_req  = 1'b1;
    run(80);
    bus.a_data = 16'h0000;
    bus.a_req  = 1'b1;
    run(80);
    bus.a_data = 16'h0050;
    bus.a_req  = 1'b1;
    run(80);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!bus.a_req && $urandom_range(0, 29) == 0) begin
        bus.a_data = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        bus.a_req  = 1'b1;
      end else if (bus.a_req && $urandom_range(0, 299) == 0) begin
        bus.a_req = 1'b0;
      end
      if (!bus.b_req && $urandom_range(0, 29) == 0) begin
        bus.b_data = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        bus.b_req  = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) bus.digit_en = 4'($urandom);
      if ($urandom_range(0, 59) == 0) bus.prio_b = ~bus.prio_b;
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
      cyc();
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
